ifetch_queue: RTL

//  Instruction-fetch stage sitting directly upstream of decode_exec. Owns the PC,

---
 rtl/ifetch_queue_pkg.sv | 31 +++
 rtl/ifetch_queue_if.sv | 37 +++
 rtl/ifetch_queue_fifo.sv | 76 +++++++
 rtl/ifetch_queue.sv | 132 +++++++++++++
 4 files changed

// File: rtl/ifetch_queue_pkg.sv
//------------------------------------------------------------------------------
// Module   : ifetch_queue_pkg
// Purpose  : Shared types and defaults for the instruction-fetch queue:
//            fetch FSM state encoding, default reset PC and the queue entry
//            layout {instruction byte, fetch address}.
// Ports    : n/a (package)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ifetch_queue_pkg;

    localparam int PKG_ADDR_W = 8;
    localparam int PKG_DATA_W = 8;

    localparam logic [PKG_ADDR_W-1:0] PKG_RESET_PC = 8'h00;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,   // no request outstanding
        REQ     = 2'd1,   // request outstanding, data will be queued
        DISCARD = 2'd2    // request outstanding, data is stale and dropped
    } fetch_state_t;

    typedef struct packed {
        logic [PKG_DATA_W-1:0] instr;
        logic [PKG_ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/ifetch_queue_if.sv
//------------------------------------------------------------------------------
// Module   : ifetch_queue_if
// Purpose  : Bundles the instruction-memory req/ack bus and the decode
//            valid/ready bus of the fetch stage.
// Ports    : master - fetch stage side (drives req/addr and decode head)
//            slave  - environment side (memory + decode)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface ifetch_queue_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    // memory read channel
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_ack_i;
    logic [DATA_W-1:0] mem_rdata_i;
    // decode channel
    logic              dec_valid_o;
    logic [DATA_W-1:0] dec_byte_o;
    logic [ADDR_W-1:0] dec_pc_o;
    logic              dec_ready_i;

    modport master (
        output mem_req_o, mem_addr_o, dec_valid_o, dec_byte_o, dec_pc_o,
        input  mem_ack_i, mem_rdata_i, dec_ready_i
    );

    modport slave (
        input  mem_req_o, mem_addr_o, dec_valid_o, dec_byte_o, dec_pc_o,
        output mem_ack_i, mem_rdata_i, dec_ready_i
    );
endinterface

`default_nettype wire

// File: rtl/ifetch_queue_fifo.sv
//------------------------------------------------------------------------------
// Module   : ifetch_queue_fifo
// Purpose  : Small synchronous FIFO holding fetched entries. Pointers carry an
//            extra MSB so full and empty are distinguished without a counter.
//            Flush empties the queue and wins over push/pop.
// Ports    : CLK, RST (async active-low)
//            push_i/push_data_i - enqueue; ignored when full
//            pop_i              - dequeue; ignored when empty
//            flush_i            - drop all entries
//            head_o             - oldest entry
//            count_o, full_o, empty_o - occupancy status
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ifetch_queue_fifo
    import ifetch_queue_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = fetch_entry_t
) (
    input  wire logic                   CLK,
    input  wire logic                   RST,
    input  wire logic                   push_i,
    input  wire T                       push_data_i,
    input  wire logic                   pop_i,
    input  wire logic                   flush_i,
    output T                            head_o,
    output logic [$clog2(DEPTH):0]      count_o,
    output logic                        full_o,
    output logic                        empty_o
);

    localparam int AW = $clog2(DEPTH);

    T               mem_q [DEPTH];
    logic [AW:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]    rd_ptr_q, rd_ptr_d;
    logic           do_push;
    logic           do_pop;

    assign count_o = wr_ptr_q - rd_ptr_q;
    assign full_o  = (count_o == (AW+1)'(DEPTH));
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i  & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (do_push && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ifetch_queue.sv
//------------------------------------------------------------------------------
// Module   : ifetch_queue
// Purpose  : Instruction-fetch stage. Owns the fetch PC, issues single-byte
//            reads over a req/ack bus (one outstanding), buffers bytes with
//            their addresses in a prefetch FIFO and hands them to decode over
//            valid/ready. A redirect reloads the PC and flushes stale bytes.
// Ports    : CLK, RST (async active-low)
//            bus (master)   - memory req/addr/ack/rdata, decode valid/byte/pc/ready
//            redirect_i     - one-cycle jump/branch pulse
//            redirect_pc_i  - redirect target
//            pc_o           - next address to fetch
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter int                ADDR_W   = PKG_ADDR_W,
    parameter int                DATA_W   = PKG_DATA_W,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = PKG_RESET_PC
) (
    input  wire logic              CLK,
    input  wire logic              RST,
    ifetch_queue_if.master         bus,
    input  wire logic              redirect_i,
    input  wire logic [ADDR_W-1:0] redirect_pc_i,
    output logic [ADDR_W-1:0]      pc_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q,    pc_d;
    // Address presented to memory. Kept apart from pc_q so a redirect during
    // DISCARD cannot disturb the address of the request still in flight.
    logic [ADDR_W-1:0] addr_q,  addr_d;

    logic              req_active;
    logic              ack;
    logic              push;
    logic              pop;
    logic              slot_free;
    logic [CW-1:0]     count;
    logic [CW:0]       count_after;
    logic              fifo_full;
    logic              fifo_empty;
    fetch_entry_t      push_entry;
    fetch_entry_t      head;

    assign req_active = (state_q != IDLE);
    assign ack        = bus.mem_ack_i & req_active;
    // Data is only kept for a live request; an ack in the redirect cycle
    // belongs to the old instruction stream.
    assign push       = ack & (state_q == REQ) & ~redirect_i & ~fifo_full;
    assign pop        = ~fifo_empty & bus.dec_ready_i;

    // Occupancy after this cycle's push/pop; a new request reserves the next
    // slot, so it may only issue while this stays below DEPTH.
    assign count_after = {1'b0, count} + {{CW{1'b0}}, push} - {{CW{1'b0}}, pop};
    assign slot_free   = (count_after < (CW+1)'(DEPTH));

    assign push_entry.instr = bus.mem_rdata_i;
    assign push_entry.pc    = addr_q;

    ifetch_queue_fifo #(
        .DEPTH (DEPTH),
        .T     (fetch_entry_t)
    ) u_fifo (
        .CLK         (CLK),
        .RST         (RST),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .flush_i     (redirect_i),
        .head_o      (head),
        .count_o     (count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!redirect_i && slot_free) state_d = REQ;
            end
            REQ: begin
                if (ack) begin
                    state_d = (redirect_i || !slot_free) ? IDLE : REQ;
                end else if (redirect_i) begin
                    state_d = DISCARD;
                end
            end
            DISCARD: begin
                if (ack) state_d = (redirect_i || !slot_free) ? IDLE : REQ;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pc_d = pc_q;
        if (redirect_i)  pc_d = redirect_pc_i;
        else if (push)   pc_d = pc_q + 1'b1;   // wraps modulo 2^ADDR_W
        // Address tracks the PC except while a stale request is draining.
        addr_d = (state_d == DISCARD) ? addr_q : pc_d;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
        end
    end

    assign bus.mem_req_o   = req_active;
    assign bus.mem_addr_o  = addr_q;
    assign bus.dec_valid_o = ~fifo_empty;
    assign bus.dec_byte_o  = fifo_empty ? '0 : head.instr;
    assign bus.dec_pc_o    = fifo_empty ? '0 : head.pc;
    assign pc_o            = pc_q;

endmodule

`default_nettype wire
